// File: rtl/add32_seq_pkg.sv
// -----------------------------------------------------------------------------
// add_seq_pkg
// Shared constants and the sequencer state type for the multi-cycle 32-bit
// adder (add32_seq) and the 16-bit ripple-carry adder it drives (fa16).
//   HALF_W  : width of one adder pass, fixed to the fa16 width
//   W       : full operand / result width, always two halves
//   state_t : sequencer states IDLE -> LO -> HI -> DONE
// -----------------------------------------------------------------------------
package add_seq_pkg;

   localparam int HALF_W = 16;
   localparam int W      = 2 * HALF_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/add32_seq_fa16.sv
// -----------------------------------------------------------------------------
// fa16
// 16-bit ripple-carry adder, purely combinational.
// Ports:
//   i_a, i_b : addend halves
//   i_cin    : carry into bit 0
//   o_sum    : sum bits
//   o_cout   : carry out of bit 15
// -----------------------------------------------------------------------------
module fa16
   import add_seq_pkg::*;
(
   input  logic [HALF_W-1:0] i_a,
   input  logic [HALF_W-1:0] i_b,
   input  logic              i_cin,
   output logic [HALF_W-1:0] o_sum,
   output logic              o_cout
);

   // Chain of full adders; the carry is a procedural variable so the ripple
   // is expressed as one ordered loop instead of a self-referencing vector.
   always_comb begin
      logic ripple;
      ripple = i_cin;
      o_sum  = '0;
      for (int i = 0; i < HALF_W; i++) begin
         o_sum[i] = i_a[i] ^ i_b[i] ^ ripple;
         ripple   = (i_a[i] & i_b[i]) | (i_a[i] & ripple) | (i_b[i] & ripple);
      end
      o_cout = ripple;
   end

endmodule

// File: rtl/add32_seq.sv
// -----------------------------------------------------------------------------
// add32_seq
// Multi-cycle 32-bit adder built on a single fa16: low halves are added in
// state LO, high halves in state HI using the registered inter-half carry,
// and the 33-bit result is offered in DONE.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   in_a, in_b, in_cin  : operands and carry-in, captured on acceptance
//   out_valid/out_ready : result handshake (valid only in DONE)
//   out_sum, out_cout   : result modulo 2^W and overflow bit
//   busy                : high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module add32_seq
   import add_seq_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_cout,
   output logic         busy
);

   state_t              r_state;
   state_t              w_nextState;
   logic [W-1:0]        r_opA;
   logic [W-1:0]        r_opB;
   logic                r_cin;
   logic [HALF_W-1:0]   r_sumLo;
   logic [HALF_W-1:0]   r_sumHi;
   logic                r_carry;
   logic                r_cout;
   logic [HALF_W-1:0]   w_addA;
   logic [HALF_W-1:0]   w_addB;
   logic                w_addCin;
   logic [HALF_W-1:0]   w_addSum;
   logic                w_addCout;

   fa16 u_fa16 (
      .i_a    (w_addA),
      .i_b    (w_addB),
      .i_cin  (w_addCin),
      .o_sum  (w_addSum),
      .o_cout (w_addCout)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state, handshake outputs and adder operand steering. The adder
   // inputs are held at zero outside LO/HI so the ripple chain stays quiet.
   // in_ready is masked by rst so nothing looks acceptable during reset.
   always_comb begin
      w_nextState = r_state;
      w_addA      = '0;
      w_addB      = '0;
      w_addCin    = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      unique case (r_state)
         IDLE: begin
            in_ready = ~rst;
            if (in_valid) begin
               w_nextState = LO;
            end
         end
         LO: begin
            w_addA      = r_opA[HALF_W-1:0];
            w_addB      = r_opB[HALF_W-1:0];
            w_addCin    = r_cin;
            w_nextState = HI;
         end
         HI: begin
            w_addA      = r_opA[W-1:HALF_W];
            w_addB      = r_opB[W-1:HALF_W];
            w_addCin    = r_carry;
            w_nextState = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath registers: operands load only on an accepted handshake, each
   // half-sum and its carry load in the state that produced them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_opA   <= '0;
         r_opB   <= '0;
         r_cin   <= 1'b0;
         r_sumLo <= '0;
         r_sumHi <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_opA <= in_a;
                  r_opB <= in_b;
                  r_cin <= in_cin;
               end
            end
            LO: begin
               r_sumLo <= w_addSum;
               r_carry <= w_addCout;
            end
            HI: begin
               r_sumHi <= w_addSum;
               r_cout  <= w_addCout;
            end
            default: begin
            end
         endcase
      end
   end

   assign out_sum  = {r_sumHi, r_sumLo};
   assign out_cout = r_cout;
   assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_add32_seq.sv
// -----------------------------------------------------------------------------
// tb_add32_seq
// Self-checking bench for add32_seq: a table of directed vectors, hand-written
// latency / backpressure / reset sequences, and a seeded random stream checked
// against a queue of expected 33-bit results.
// -----------------------------------------------------------------------------
module tb_add32_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_cout;
   logic        busy;

   int nCompared   = 0;
   int nMismatched = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] expSum;
      logic        expCout;
   } vec_t;

   vec_t vecs [9];

   add32_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .busy      (busy)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a sequence wedges despite its own bounds.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it and reports a FAIL line on disagreement.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Drives one operand pair from a negedge and holds it until accepted;
   // returns at the negedge of the first cycle after acceptance (state LO).
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin);
      int guard;
      guard    = 0;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         checkOutput("accept_timeout", 64'(in_ready), 64'd1);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Waits (bounded) for out_valid, captures the result, completes the
   // handshake and returns at the negedge of the following IDLE cycle.
   task automatic waitResult(output logic [32:0] res);
      int guard;
      guard = 0;
      while (!out_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("result_wait", 64'(out_valid), 64'd1);
      res       = {out_cout, out_sum};
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [32:0] res;
      int          seed;
      int          sent;
      int          recv;
      int          cyc;
      logic        accepted;
      logic [32:0] expQ [$];
      logic [32:0] expRes;

      vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0};
      vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
      vecs[2] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
      vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
      vecs[4] = '{32'h00000001, 32'h00000002, 1'b1, 32'h00000004, 1'b0};
      vecs[5] = '{32'hFFFF0000, 32'h0000FFFF, 1'b1, 32'h00000000, 1'b1};
      vecs[6] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
      vecs[7] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
      vecs[8] = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b0;

      // Reset state while rst is still high.
      #13;
      checkOutput("rst_in_ready",  64'(in_ready),  64'd0);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_busy",      64'(busy),      64'd0);
      checkOutput("rst_out_sum",   64'(out_sum),   64'd0);
      checkOutput("rst_out_cout",  64'(out_cout),  64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

      // Directed vector table.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
         waitResult(res);
         checkOutput($sformatf("vec%0d", i), 64'(res), 64'({vecs[i].expCout, vecs[i].expSum}));
      end

      // Latency and ignore-while-busy: DEADBEEF is offered during LO/HI/DONE.
      in_a     = 32'h12345678;
      in_b     = 32'h11111111;
      in_cin   = 1'b0;
      in_valid = 1'b1;
      checkOutput("lat_ready_k", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_a = 32'hDEADBEEF;
      in_b = 32'h00000001;
      for (int c = 1; c <= 3; c++) begin
         checkOutput($sformatf("lat_in_ready_k%0d", c), 64'(in_ready), 64'd0);
         checkOutput($sformatf("lat_out_valid_k%0d", c), 64'(out_valid), 64'(c == 3));
         if (c < 3) @(negedge clk);
      end
      checkOutput("lat_result", 64'({out_cout, out_sum}), 64'({1'b0, 32'h23456789}));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("lat_idle_valid", 64'(out_valid), 64'd0);
      checkOutput("lat_idle_ready", 64'(in_ready),  64'd1);
      @(negedge clk);
      checkOutput("lat_second_busy", 64'(busy), 64'd1);
      in_valid = 1'b0;
      waitResult(res);
      checkOutput("lat_second_result", 64'(res), 64'({1'b0, 32'hDEADBEF0}));

      // Backpressure: result must hold for 5 cycles with out_ready low.
      applyStimulus(32'h80000000, 32'h80000000, 1'b0);
      @(negedge clk);
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("bp_valid_%0d", c),    64'(out_valid), 64'd1);
         checkOutput($sformatf("bp_result_%0d", c),   64'({out_cout, out_sum}), 64'({1'b1, 32'h00000000}));
         checkOutput($sformatf("bp_in_ready_%0d", c), 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("bp_release_valid", 64'(out_valid), 64'd0);
      checkOutput("bp_release_busy",  64'(busy),      64'd0);

      // Reset while in HI: outputs drop immediately, next op is clean.
      applyStimulus(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1);
      @(negedge clk);
      checkOutput("hi_busy", 64'(busy), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("hi_rst_valid", 64'(out_valid), 64'd0);
      checkOutput("hi_rst_busy",  64'(busy),      64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_valid", 64'(out_valid), 64'd0);
      applyStimulus(32'h00000001, 32'h00000002, 1'b1);
      waitResult(res);
      checkOutput("post_rst_result", 64'(res), 64'({1'b0, 32'h00000004}));

      // Random stream: drive at negedge, decide handshakes just before posedge.
      seed     = 32'h1234ABCD;
      sent     = 0;
      recv     = 0;
      cyc      = 0;
      accepted = 1'b0;
      while (recv < 200 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (accepted) begin
            in_valid = 1'b0;
            accepted = 1'b0;
         end
         if (!in_valid && sent < 200 && ($random(seed) & 1)) begin
            in_a     = $random(seed);
            in_b     = $random(seed);
            in_cin   = $random(seed) & 1;
            in_valid = 1'b1;
         end
         out_ready = (($random(seed) & 3) != 0);
         #4;
         if (in_valid && in_ready) begin
            expQ.push_back({1'b0, in_a} + {1'b0, in_b} + 33'(in_cin));
            sent++;
            accepted = 1'b1;
         end
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("rand_spurious", 64'(recv), 64'(sent));
            end else begin
               expRes = expQ.pop_front();
               checkOutput($sformatf("rand_op%0d", recv), 64'({out_cout, out_sum}), 64'(expRes));
            end
            recv++;
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("rand_recv_count", 64'(recv), 64'd200);
      checkOutput("rand_sent_count", 64'(sent), 64'd200);
      checkOutput("rand_queue_empty", 64'(expQ.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
